// File: rtl/bk_mem_pkg.sv
// Shared definitions for the BK-0010 main-RAM arbiter: FSM states, RAM limit, lane codes.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package bk_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VID   = 3'd1,
        ST_CRD   = 3'd2,
        ST_CWR   = 3'd3,
        ST_CHOLD = 3'd4
    } arb_st_t;

    // Top of the 32 KB main RAM as a CPU byte address.
    localparam logic [15:0] RAM_LIMIT = 16'o077777;

    // Byte-lane enables packed as {ub_n, lb_n}, active low.
    localparam logic [1:0] LANE_BOTH  = 2'b00;
    localparam logic [1:0] LANE_UPPER = 2'b01;
    localparam logic [1:0] LANE_LOWER = 2'b10;
    localparam logic [1:0] LANE_NONE  = 2'b11;

    // Byte accesses use address bit 0 to pick the lane; 1 selects the upper byte.
    function automatic logic [1:0] lane_sel(input logic byte_acc, input logic a0);
        if (!byte_acc)
            return LANE_BOTH;
        return a0 ? LANE_UPPER : LANE_LOWER;
    endfunction

endpackage

// File: rtl/bk_mem_arbiter_if.sv
// Bundle of the CPU bus, video fetch port and split-data SRAM pins around bk_mem_arbiter.
// Latency: n/a (wiring only).
// Backpressure: CPU held off by withholding cpu_reply; video held off by withholding vid_ack.
// Modports: slave = the arbiter, master = the CPU/video/SRAM side.
interface bk_mem_arbiter_if;

    logic        cpu_rd;
    logic        cpu_wt;
    logic        cpu_byte;
    logic [15:0] cpu_adr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_reply;

    logic        vid_req;
    logic [13:0] vid_adr;
    logic        vid_ack;
    logic [15:0] vid_data;

    logic [13:0] sram_a;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport slave (
        input  cpu_rd, cpu_wt, cpu_byte, cpu_adr, cpu_din,
        output cpu_dout, cpu_reply,
        input  vid_req, vid_adr,
        output vid_ack, vid_data,
        output sram_a, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        input  sram_dq_i
    );

    modport master (
        output cpu_rd, cpu_wt, cpu_byte, cpu_adr, cpu_din,
        input  cpu_dout, cpu_reply,
        output vid_req, vid_adr,
        input  vid_ack, vid_data,
        input  sram_a, sram_dq_o, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        output sram_dq_i
    );

endinterface

// File: rtl/bk_acc_timer.sv
// Loadable down-counter timing one SRAM access; done is high while the count is zero.
// Latency: load takes effect at the ce edge it is sampled on; one decrement per ce edge.
// Backpressure: none; holds its value while ce is low.
// Ports: clk, reset_n, ce, load, load_val -> done.
module bk_acc_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (ce) begin
            if (load)
                cnt <= load_val;
            else if (cnt != '0)
                cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/bk_mem_arbiter.sv
// Single-port SRAM controller sharing BK-0010 main RAM between the CPU bus and video fetches.
// Latency: ACC_CYCLES ce cycles per access plus one idle ce cycle between accesses.
// Backpressure: video has priority (strict, or bounded by VID_MAX when BK_ARB_FAIR_EN is defined);
//               the CPU waits for cpu_reply, video waits for vid_ack.
// Ports: clk, reset_n (async, active low), ce, bus (bk_mem_arbiter_if.slave).
module bk_mem_arbiter
    import bk_mem_pkg::*;
#(
    parameter int ACC_CYCLES = 2,
    parameter int VID_MAX    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce,
    bk_mem_arbiter_if.slave bus
);

    localparam logic [2:0] ACC_LOAD = 3'(ACC_CYCLES - 1);
    localparam logic [2:0] VID_LIM  = 3'(VID_MAX);

    arb_st_t     state, state_nxt;
    logic [13:0] acc_adr;
    logic [1:0]  acc_lane;
    logic [15:0] acc_din;
    logic [15:0] cpu_dout_r;
    logic [15:0] vid_data_r;
    logic        vid_ack_r;
    logic        tmr_done;
    logic        grant;
    logic        cpu_rq;
    logic        cpu_force;
    logic [13:0] cpu_wadr;

    assign cpu_rq   = bus.cpu_rd | bus.cpu_wt;
    // Bit 15 lies above the 32 KB RAM; bit 0 only selects a byte lane.
    assign cpu_wadr = bus.cpu_adr[14:1] & RAM_LIMIT[14:1];
    assign grant    = (state == ST_IDLE) && (state_nxt != ST_IDLE);

`ifdef BK_ARB_FAIR_EN
    // Counts video grants made back-to-back while the CPU was waiting.
    logic [2:0] fair_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fair_cnt <= '0;
        end else if (ce && grant) begin
            if (state_nxt != ST_VID)
                fair_cnt <= '0;
            else if (!cpu_rq)
                fair_cnt <= '0;
            else if (fair_cnt != 3'd7)
                fair_cnt <= fair_cnt + 3'd1;
        end
    end

    assign cpu_force = cpu_rq && (fair_cnt >= VID_LIM);
`else
    logic [2:0] unused_vid_lim;
    assign unused_vid_lim = VID_LIM;
    assign cpu_force      = 1'b0;
`endif

    bk_acc_timer #(.W(3)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .load     (grant),
        .load_val (ACC_LOAD),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else if (ce)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.vid_req && !cpu_force)
                    state_nxt = ST_VID;
                else if (bus.cpu_rd)          // rd+wt together is treated as a read
                    state_nxt = ST_CRD;
                else if (bus.cpu_wt)
                    state_nxt = ST_CWR;
            end
            ST_VID: begin
                if (tmr_done)
                    state_nxt = ST_IDLE;
            end
            ST_CRD, ST_CWR: begin
                // Strobes dropping mid-access abandon it without a reply.
                if (!cpu_rq)
                    state_nxt = ST_IDLE;
                else if (tmr_done)
                    state_nxt = ST_CHOLD;
            end
            ST_CHOLD: begin
                if (!cpu_rq)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address, lanes and write data are captured at grant so they stay fixed for the access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_adr    <= '0;
            acc_lane   <= LANE_NONE;
            acc_din    <= '0;
            cpu_dout_r <= '0;
            vid_data_r <= '0;
            vid_ack_r  <= 1'b0;
        end else if (ce) begin
            vid_ack_r <= 1'b0;
            if (grant) begin
                if (state_nxt == ST_VID) begin
                    acc_adr  <= bus.vid_adr;
                    acc_lane <= LANE_BOTH;
                end else begin
                    acc_adr  <= cpu_wadr;
                    acc_lane <= (state_nxt == ST_CWR) ? lane_sel(bus.cpu_byte, bus.cpu_adr[0])
                                                      : LANE_BOTH;
                    acc_din  <= bus.cpu_din;
                end
            end
            if (state == ST_VID && tmr_done) begin
                vid_data_r <= bus.sram_dq_i;
                vid_ack_r  <= 1'b1;
            end
            if (state == ST_CRD && state_nxt == ST_CHOLD)
                cpu_dout_r <= bus.sram_dq_i;
        end
    end

    always_comb begin
        bus.sram_a     = acc_adr;
        bus.sram_dq_o  = acc_din;
        bus.sram_oe_n  = 1'b1;
        bus.sram_we_n  = 1'b1;
        bus.sram_dq_oe = 1'b0;
        {bus.sram_ub_n, bus.sram_lb_n} = LANE_NONE;
        bus.cpu_reply  = (state == ST_CHOLD);
        bus.cpu_dout   = cpu_dout_r;
        bus.vid_ack    = vid_ack_r;
        bus.vid_data   = vid_data_r;
        case (state)
            ST_VID, ST_CRD: begin
                bus.sram_oe_n = 1'b0;
                {bus.sram_ub_n, bus.sram_lb_n} = acc_lane;
            end
            ST_CWR: begin
                bus.sram_we_n  = 1'b0;
                bus.sram_dq_oe = 1'b1;
                {bus.sram_ub_n, bus.sram_lb_n} = acc_lane;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Bench for bk_mem_arbiter: directed scenarios then randomized CPU/video traffic.
// Expected read data comes from a word-array model updated with plain byte/word merge rules;
// a monitor pops expectations whenever vid_ack or a rising cpu_reply appears.
module tb_bk_mem_arbiter;

    localparam int ACC  = 2;
    localparam int VMAX = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ce      = 1'b1;
    bit   rand_ce = 1'b0;

    always #5 clk = ~clk;

    bk_mem_arbiter_if bus();

    bk_mem_arbiter #(.ACC_CYCLES(ACC), .VID_MAX(VMAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    // Physical SRAM seen by the DUT, and the bench's reference view of it.
    logic [15:0] sram  [0:16383];
    logic [15:0] model [0:16383];

    assign bus.sram_dq_i = bus.sram_oe_n ? 16'h0000 : sram[bus.sram_a];

    always @(posedge clk) begin
        if (!bus.sram_we_n && bus.sram_dq_oe) begin
            if (!bus.sram_ub_n) sram[bus.sram_a][15:8] <= bus.sram_dq_o[15:8];
            if (!bus.sram_lb_n) sram[bus.sram_a][7:0]  <= bus.sram_dq_o[7:0];
        end
    end

    typedef struct packed {
        logic        is_rd;
        logic [15:0] data;
    } cexp_t;

    cexp_t       cpu_q[$];
    logic [15:0] vid_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on each ce-qualified vid_ack and each rising cpu_reply.
    logic  reply_q = 1'b0;
    cexp_t ce_exp;
    always @(negedge clk) begin
        if (!reset_n) begin
            reply_q = 1'b0;
        end else begin
            if (ce && bus.vid_ack) begin
                check("vid_ack_expected", 32'(vid_q.size() != 0), 32'd1);
                if (vid_q.size() != 0)
                    check("vid_data", bus.vid_data, vid_q.pop_front());
            end
            if (bus.cpu_reply && !reply_q) begin
                check("cpu_reply_expected", 32'(cpu_q.size() != 0), 32'd1);
                if (cpu_q.size() != 0) begin
                    ce_exp = cpu_q.pop_front();
                    if (ce_exp.is_rd)
                        check("cpu_dout", bus.cpu_dout, ce_exp.data);
                end
            end
            reply_q = bus.cpu_reply;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ce)
            ce = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_reply(input int limit, output int edges);
        edges = 0;
        while (!bus.cpu_reply && edges < limit) begin
            step();
            edges++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t, limit 2000000", $time);
        $fatal(1);
    end

    int          edges, acks, ack_edge, rep_edge, bad_adr, we_cnt, seen, n, op;
    logic        ub_s, lb_s;
    bit          dov, hi, b15, cpu_pend, vid_pend;
    logic [13:0] w, vw;
    logic [15:0] d, nv;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            d        = 16'($urandom);
            sram[i]  = d;
            model[i] = d;
        end
        sram[256]  = 16'o123456;
        model[256] = 16'o123456;

        bus.cpu_rd = 0; bus.cpu_wt = 0; bus.cpu_byte = 0;
        bus.cpu_adr = '0; bus.cpu_din = '0;
        bus.vid_req = 0; bus.vid_adr = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_reply",   bus.cpu_reply, 0);
        check("rst_vid_ack", bus.vid_ack, 0);
        check("rst_dout",    bus.cpu_dout, 0);
        check("rst_vdata",   bus.vid_data, 0);
        check("rst_sram_a",  bus.sram_a, 0);
        check("rst_ctl_n",   {bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 4'hF);
        check("rst_dq_oe",   bus.sram_dq_oe, 0);
        @(negedge clk) reset_n = 1'b1;
        step();

        // CPU read of 'o001000: reply visible after ACC+1 ce edges counted from strobe rise.
        cpu_q.push_back({1'b1, model[256]});
        bus.cpu_adr = 16'o001000; bus.cpu_rd = 1;
        wait_reply(20, edges);
        check("rd_latency", edges, ACC + 1);
        check("rd_dout_const", bus.cpu_dout, 16'o123456);
        bus.cpu_rd = 0;
        step();
        check("rd_reply_drop", bus.cpu_reply, 0);
        step();

        // Byte write of 'o052 (lane-duplicated) to odd address 'o001001: upper lane only.
        cpu_q.push_back({1'b0, 16'h0});
        model[256] = {8'o052, model[256][7:0]};
        bus.cpu_adr = 16'o001001; bus.cpu_byte = 1; bus.cpu_din = 16'o025052; bus.cpu_wt = 1;
        we_cnt = 0; ub_s = 1; lb_s = 0; edges = 0;
        while (!bus.cpu_reply && edges < 20) begin
            step();
            edges++;
            if (!bus.sram_we_n) begin
                we_cnt++;
                ub_s = bus.sram_ub_n;
                lb_s = bus.sram_lb_n;
            end
        end
        check("bw_we_cycles", we_cnt, ACC);
        check("bw_ub_n", ub_s, 0);
        check("bw_lb_n", lb_s, 1);
        bus.cpu_wt = 0; bus.cpu_byte = 0;
        step(); step();
        cpu_q.push_back({1'b1, model[256]});
        bus.cpu_adr = 16'o001000; bus.cpu_rd = 1;
        wait_reply(20, edges);
        check("bw_readback_upper", bus.cpu_dout[15:8], 8'o052);
        check("bw_readback_lower", bus.cpu_dout[7:0], 8'h2E);
        bus.cpu_rd = 0;
        step(); step();

        // Video and CPU rise together: one video access first, then the CPU.
        vid_q.push_back(model[5000]);
        cpu_q.push_back({1'b1, model[512]});
        bus.vid_adr = 14'd5000; bus.vid_req = 1;
        bus.cpu_adr = 16'o002000; bus.cpu_rd = 1;
        edges = 0; acks = 0; ack_edge = 0; rep_edge = 0; bad_adr = 0;
        while (rep_edge == 0 && edges < 40) begin
            step();
            edges++;
            if (!bus.sram_oe_n && ack_edge == 0 && bus.sram_a != 14'd5000) bad_adr++;
            if (bus.vid_ack) begin
                acks++;
                if (ack_edge == 0) ack_edge = edges;
                bus.vid_req = 0;
            end
            if (bus.cpu_reply) rep_edge = edges;
        end
        check("arb_vid_latency", ack_edge, ACC + 1);
        check("arb_cpu_latency", rep_edge, 2 * (ACC + 1));
        check("arb_ack_count", acks, 1);
        check("arb_vid_addr_only", bad_adr, 0);
        bus.cpu_rd = 0;
        step(); step();

        // CPU read abandoned mid-access: no reply, SRAM released on the next edge.
        bus.cpu_adr = 16'o003000; bus.cpu_rd = 1;
        step();
        check("abort_in_access", bus.sram_oe_n, 0);
        bus.cpu_rd = 0;
        step();
        check("abort_oe_n", bus.sram_oe_n, 1);
        seen = 0;
        repeat (6) begin
            if (bus.cpu_reply) seen = 1;
            step();
        end
        check("abort_no_reply", seen, 0);

        // Video held high with a CPU read pending.
        for (int i = 0; i < 200; i++) vid_q.push_back(model[100]);
        bus.vid_adr = 14'd100; bus.vid_req = 1;
        bus.cpu_adr = 16'o004000; bus.cpu_rd = 1;
`ifdef BK_ARB_FAIR_EN
        cpu_q.push_back({1'b1, model[1024]});
        acks = 0; edges = 0;
        while (!bus.cpu_reply && edges < 100) begin
            step();
            edges++;
            if (bus.vid_ack) acks++;
        end
        check("fair_acks_before_reply", acks, VMAX);
        check("fair_reply", bus.cpu_reply, 1);
        bus.cpu_rd = 0;
`else
        acks = 0; seen = 0;
        repeat (100) begin
            step();
            if (bus.vid_ack) acks++;
            if (bus.cpu_reply) seen = 1;
        end
        check("starve_no_reply", seen, 0);
        check("starve_video_busy", 32'(acks >= 30), 32'd1);
        bus.cpu_rd = 0;
`endif
        bus.vid_req = 0;
        repeat (8) step();
        vid_q.delete();

        // Reset pulsed during a CPU write releases the SRAM at once.
        bus.cpu_adr = 16'o005000; bus.cpu_byte = 0; bus.cpu_din = 16'hBEEF; bus.cpu_wt = 1;
        step();
        check("cwr_we_low", bus.sram_we_n, 0);
        check("cwr_dq_oe", bus.sram_dq_oe, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_we_n", bus.sram_we_n, 1);
        check("arst_dq_oe", bus.sram_dq_oe, 0);
        bus.cpu_wt = 0;
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step();
        check("post_rst_ctl_n", {bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 4'hF);
        check("post_rst_dout", bus.cpu_dout, 0);
        cpu_q.push_back({1'b1, model[1280]});
        bus.cpu_adr = 16'o005000; bus.cpu_rd = 1;
        wait_reply(20, edges);
        check("post_rst_rd_latency", edges, ACC + 1);
        bus.cpu_rd = 0;
        step(); step();

        // Randomized traffic with a gated ce.
        rand_ce = 1'b1;
        for (int it = 0; it < 60; it++) begin
            op  = $urandom_range(0, 3);
            dov = ($urandom_range(0, 1) == 1) || (op == 0);
            w   = 14'($urandom_range(0, 63));
            vw  = 14'($urandom_range(0, 63));
            d   = 16'($urandom);
            hi  = 1'($urandom_range(0, 1));
            b15 = 1'($urandom_range(0, 1));
            if (op >= 2 && dov && vw == w) vw = w ^ 14'd1;
            if (dov) begin
                vid_q.push_back(model[vw]);
                bus.vid_adr = vw;
                bus.vid_req = 1;
            end
            case (op)
                1: begin
                    cpu_q.push_back({1'b1, model[w]});
                    bus.cpu_adr = {b15, w, hi}; bus.cpu_byte = hi; bus.cpu_rd = 1;
                end
                2: begin
                    cpu_q.push_back({1'b0, 16'h0});
                    model[w] = d;
                    bus.cpu_adr = {b15, w, 1'b0}; bus.cpu_byte = 0; bus.cpu_din = d; bus.cpu_wt = 1;
                end
                3: begin
                    cpu_q.push_back({1'b0, 16'h0});
                    nv = hi ? {d[7:0], model[w][7:0]} : {model[w][15:8], d[7:0]};
                    model[w] = nv;
                    bus.cpu_adr = {b15, w, hi}; bus.cpu_byte = 1;
                    bus.cpu_din = {d[7:0], d[7:0]}; bus.cpu_wt = 1;
                end
                default: ;
            endcase
            cpu_pend = (op != 0);
            vid_pend = dov;
            n = 0;
            while ((cpu_pend || vid_pend || bus.cpu_reply || bus.vid_ack) && n < 300) begin
                step();
                n++;
                if (vid_pend && bus.vid_ack) begin bus.vid_req = 0; vid_pend = 0; end
                if (cpu_pend && bus.cpu_reply) begin bus.cpu_rd = 0; bus.cpu_wt = 0; cpu_pend = 0; end
            end
            check("rand_op_completed", {cpu_pend, vid_pend}, 0);
            bus.cpu_rd = 0; bus.cpu_wt = 0; bus.vid_req = 0;
        end
        rand_ce = 1'b0;
        ce = 1'b1;
        repeat (4) step();
        check("cpu_q_drained", cpu_q.size(), 0);
        check("vid_q_drained", vid_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
